// File: rtl/ysyx_icache.sv
// Direct-mapped, blocking instruction cache with word-at-a-time refill over a
// simple AR/R bus, redirect (flush) and fence.i handling, and hit/miss counters.

module ysyx_icache_line #(
  parameter int TAG_W      = 24,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int K_W        = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 inv_all,
  input  logic                                 wr_en,
  input  logic [K_W-1:0]                       wr_word,
  input  logic [DATA_W-1:0]                    wr_data,
  input  logic                                 set_en,
  input  logic [TAG_W-1:0]                     set_tag,
  output logic                                 vld,
  output logic [TAG_W-1:0]                     tag,
  output logic [LINE_WORDS-1:0][DATA_W-1:0]    data
);
  // Invalidate beats install so a fence never leaves a stale line behind.
  always_ff @(posedge clk) begin
    if (!rst)         vld <= 1'b0;
    else if (inv_all) vld <= 1'b0;
    else if (set_en)  vld <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (set_en) tag <= set_tag;
  end

  for (genvar w = 0; w < LINE_WORDS; w++) begin : g_word
    always_ff @(posedge clk) begin
      if (wr_en && wr_word == K_W'(w)) data[w] <= wr_data;
    end
  end
endmodule

module ysyx_icache #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_inst,
  output logic [ADDR_W-1:0] resp_pc,
  input  logic              flush,
  input  logic              fence_i,
  output logic [ADDR_W-1:0] bus_araddr,
  output logic              bus_arvalid,
  input  logic              bus_arready,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_rvalid,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);
  localparam int OFF_B = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int K_W   = (OFF_B > 0) ? OFF_B : 1;
  localparam int TAG_W = ADDR_W - 2 - OFF_B - IDX_W;
  localparam logic [K_W-1:0] LAST = K_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL_AR, REFILL_R, RESP} state_t;

  typedef struct packed {
    logic              en;
    logic [K_W-1:0]    word;
    logic [DATA_W-1:0] data;
  } fill_t;

  state_t            state;
  logic [K_W-1:0]    k;
  logic [DATA_W-1:0] resp_buf;
  logic              flush_pend, fence_pend;

  logic [SETS-1:0]                             line_vld;
  logic [SETS-1:0][TAG_W-1:0]                  line_tag;
  logic [SETS-1:0][LINE_WORDS-1:0][DATA_W-1:0] line_data;

  logic [K_W-1:0]    off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag_q;
  logic [ADDR_W-1:0] line_base;
  logic              hit, inv_all, install;
  fill_t             fill;

  // All lookup/refill addressing derives from the registered PC.
  assign off       = K_W'((resp_pc >> 2) & ADDR_W'(LINE_WORDS - 1));
  assign idx       = IDX_W'(resp_pc >> (2 + OFF_B));
  assign tag_q     = TAG_W'(resp_pc >> (2 + OFF_B + IDX_W));
  assign line_base = resp_pc & ~ADDR_W'(LINE_WORDS * 4 - 1);
  assign hit       = line_vld[idx] && (line_tag[idx] == tag_q);

  assign fill.en   = (state == REFILL_R) && bus_rvalid;
  assign fill.word = k;
  assign fill.data = bus_rdata;
  assign install   = fill.en && (k == LAST);
  assign inv_all   = (state == IDLE) && (fence_i || fence_pend);

  for (genvar s = 0; s < SETS; s++) begin : g_set
    ysyx_icache_line #(
      .TAG_W(TAG_W), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS), .K_W(K_W)
    ) u_line (
      .clk    (clk),
      .rst    (rst),
      .inv_all(inv_all),
      .wr_en  (fill.en && idx == IDX_W'(s)),
      .wr_word(fill.word),
      .wr_data(fill.data),
      .set_en (install && idx == IDX_W'(s)),
      .set_tag(tag_q),
      .vld    (line_vld[s]),
      .tag    (line_tag[s]),
      .data   (line_data[s])
    );
  end

  assign req_ready   = (state == IDLE) && !fence_i && !fence_pend;
  assign resp_valid  = !flush && (((state == LOOKUP) && hit) || (state == RESP));
  assign bus_arvalid = (state == REFILL_AR);
  assign bus_araddr  = bus_arvalid ? line_base + (ADDR_W'(k) << 2) : '0;

  always_comb begin
    resp_inst = '0;
    case (state)
      LOOKUP:  resp_inst = line_data[idx][off];
      RESP:    resp_inst = resp_buf;
      default: resp_inst = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      k          <= '0;
      resp_buf   <= '0;
      resp_pc    <= '0;
      flush_pend <= 1'b0;
      fence_pend <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      if (inv_all)      fence_pend <= 1'b0;
      else if (fence_i) fence_pend <= 1'b1;

      // A redirect during refill is remembered; the line still gets installed.
      if (flush && (state == REFILL_AR || state == REFILL_R)) flush_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            resp_pc <= req_addr;
            state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (flush) begin
            state <= IDLE;
          end else if (hit) begin
            if (resp_ready) begin
              state   <= IDLE;
              hit_cnt <= hit_cnt + CNT_W'(1);
            end
          end else begin
            state    <= REFILL_AR;
            k        <= '0;
            resp_buf <= '0;
            miss_cnt <= miss_cnt + CNT_W'(1);
          end
        end
        REFILL_AR: begin
          if (bus_arready) state <= REFILL_R;
        end
        REFILL_R: begin
          if (bus_rvalid) begin
            if (k == off) resp_buf <= bus_rdata;
            if (k != LAST) begin
              k     <= k + K_W'(1);
              state <= REFILL_AR;
            end else begin
              flush_pend <= 1'b0;
              state      <= (flush || flush_pend) ? IDLE : RESP;
            end
          end
        end
        RESP: begin
          if (flush || resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/ysyx_icache.md
YSYX_ICACHE -- requirements
Module: ysyx_icache

Interface
REQ-001 SHALL be parametrised as follows: ADDR_W, default 32, address width.
REQ-002 SHALL be parametrised as follows: DATA_W, default 32, instruction/bus word width.
REQ-003 SHALL be parametrised as follows: SETS, default 16, number of direct-mapped lines (power of 2, >=2).
REQ-004 SHALL be parametrised as follows: LINE_WORDS, default 4, words per line (power of 2, >=1).
REQ-005 SHALL be parametrised as follows: CNT_W, default 32, statistics counter width.
REQ-006 SHALL have one clock and a synchronous, active-low reset: clk input 1, the only clock; rst input 1, synchronous active-low reset.
REQ-007 SHALL have these request ports: req_valid input 1, fetch request; req_ready output 1, request accepted; req_addr input ADDR_W, word-aligned fetch PC.
REQ-008 SHALL have these response ports: resp_valid output 1; resp_ready input 1; resp_inst output DATA_W, instruction; resp_pc output ADDR_W, PC of that instruction.
REQ-009 SHALL have these control ports: flush input 1, redirect, drop outstanding response; fence_i input 1, invalidate all lines.
REQ-010 SHALL have these bus ports: bus_araddr output ADDR_W; bus_arvalid output 1; bus_arready input 1; bus_rdata input DATA_W; bus_rvalid input 1.
REQ-011 SHALL have these statistics ports: hit_cnt output CNT_W; miss_cnt output CNT_W.

Function
REQ-012 SHALL split the address as follows: offset = addr[log2(LINE_WORDS)+1:2]; index = the next log2(SETS) bits; tag = the remaining upper bits.
REQ-013 SHALL use the states IDLE, LOOKUP, REFILL_AR, REFILL_R, RESP.
REQ-014 SHALL drive req_ready = (state==IDLE) & !fence_i & !fence_pend; on a request handshake, req_addr SHALL be registered into resp_pc and the state SHALL go to LOOKUP.
REQ-015 SHALL handle LOOKUP as follows: on a hit (line valid and tag equal), resp_valid=1 combinationally and resp_inst = the stored word at the offset; on resp_ready the state SHALL go to IDLE, else stay in LOOKUP with the response held stable.
REQ-016 SHALL, on a LOOKUP miss, go to REFILL_AR with beat counter k=0 and the response buffer cleared.
REQ-017 SHALL, in REFILL_AR, drive bus_arvalid=1 and bus_araddr = line base + 4*k until bus_arready; the handshake cycle SHALL move the state to REFILL_R.
REQ-018 SHALL, in REFILL_R on bus_rvalid, write bus_rdata into word k of the line; if k equals the request offset, the data SHALL also be captured into the response buffer.
REQ-019 SHALL, at the REFILL_R beat that ends a word: if k<LINE_WORDS-1, increment k and go to REFILL_AR; else set the tag and valid bit and go to RESP.
REQ-020 SHALL, in RESP, present resp_valid=1 with resp_inst from the response buffer until resp_ready, then go to IDLE.
REQ-021 SHALL count as follows: hit_cnt +1 on a LOOKUP response handshake; miss_cnt +1 on the LOOKUP->REFILL_AR transition; both SHALL wrap modulo 2^CNT_W.
REQ-022 SHALL handle flush in IDLE, LOOKUP or RESP as follows: resp_valid forced 0 that cycle, state -> IDLE next cycle, no count.
REQ-023 SHALL handle flush in REFILL_AR or REFILL_R as follows: set flush_pend; the refill SHALL complete and install the line, then go to IDLE without asserting resp_valid; flush_pend SHALL then clear.
REQ-024 SHALL handle fence_i in IDLE as follows: clear all valid bits at that edge; a req_valid in the same cycle SHALL NOT be accepted.
REQ-025 SHALL handle fence_i outside IDLE as follows: set fence_pend; clear all valid bits on the first IDLE cycle; keep req_ready=0 until cleared.
REQ-026 SHALL treat fence_i and flush asserted together as both taking effect independently.
REQ-027 SHALL never assert bus_arvalid outside REFILL_AR; bus_arvalid and bus_araddr SHALL be stable while waiting for arready.
REQ-028 SHALL ignore a bus_rvalid that arrives outside REFILL_R.

Reset
REQ-029 SHALL, with rst==0 at a clk edge, enter state IDLE and clear all valid bits, k, fence_pend and flush_pend.
REQ-030 SHALL, on that reset, clear hit_cnt and miss_cnt.
REQ-031 SHALL, on that reset, drive resp_valid=0, bus_arvalid=0, resp_pc=0, resp_inst=0 and bus_araddr=0.
REQ-032 SHALL, on reset during a refill, abandon the refill with bus_arvalid low the next cycle and the partially filled line left invalid.

Verification
REQ-033 SHALL cover a cold miss: defaults, request 0x8000_0008, bus returns 0xA0..0xA3 with arready/rvalid 1-cycle latency -> reads at 0x8000_0000/4/8/C in order, resp_inst=0xA2, resp_pc=0x8000_0008, miss_cnt=1.
REQ-034 SHALL cover a hit after fill: request 0x8000_0004 -> resp_valid in the cycle after acceptance, resp_inst=0xA1, no bus_arvalid, hit_cnt=1.
REQ-035 SHALL cover a conflict: request 0x8000_0100 (same index, different tag) -> refill, then request 0x8000_0000 misses again, miss_cnt=3.
REQ-036 SHALL cover a flush mid-refill: flush pulse in the beat-1 REFILL_R -> all 4 beats complete, no resp_valid, a later request for that line hits.
REQ-037 SHALL cover fence_i: fence_i while in RESP with resp_ready=0 -> req_ready stays 0 until IDLE plus one cycle, then the next request to a filled line misses.
REQ-038 SHALL cover backpressure and reset: resp_ready=0 for 5 cycles on a hit -> resp_inst/resp_pc stable and hit_cnt unchanged until the handshake; rst=0 during REFILL_R -> counters 0, bus_arvalid 0 next cycle.
